aesl_axis_stall_detector: RTL and testbench

// - Generates the per-channel AXI-Stream blocking indications (axis_block_sigs) consumed by the
//   co-simulation deadlock monitors of the yolo_acc_top harness.
// - Watches the TVALID/TREADY pair of every DUT stream port and flags a channel once the DUT side
//   has been starved (input port) or back-pressured (output port) for STALL_THRESH consecutive cycles.
// - Also records which channel blocked first, to help debug deadlocks.

---
 rtl/aesl_axis_stall_detector.sv | 132 +++++++++++++
 tb/tb_aesl_axis_stall_detector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/aesl_axis_stall_detector.sv
// Per-channel AXI-Stream stall watchdog: flags a channel after STALL_THRESH consecutive
// starved/back-pressured cycles and records the first channel to block.
module aesl_axis_stall_detector #(
  parameter int                NUM_CH       = 4,
  parameter int                STALL_THRESH = 1024,
  parameter int                CNT_W        = 16,
  parameter logic [NUM_CH-1:0] DIR_MASK     = 4'b0011,
  localparam int               IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] axis_tvalid,
  input  logic [NUM_CH-1:0] axis_tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              block_any,
  output logic              first_valid,
  output logic [IDX_W-1:0]  first_idx,
  output logic [15:0]       block_events
);

  typedef enum logic [1:0] {IDLE, COUNT, BLOCKED} state_t;

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);

  state_t            state_p0 [NUM_CH];
  state_t            state_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_p0   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] blk_d;
  logic [NUM_CH-1:0] entry;
  logic [IDX_W-1:0]  first_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_add_events(input logic [15:0] base,
                                                 input logic [NUM_CH-1:0] hits);
    logic [16:0] sum;
    sum = {1'b0, base};
    for (int c = 0; c < NUM_CH; c++) sum = sum + 17'(hits[c]);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_comb begin
    first_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // Input ports stall when the DUT waits for data; output ports when it is back-pressured
      stall[c]   = DIR_MASK[c] ? (axis_tready[c] & ~axis_tvalid[c])
                               : (axis_tvalid[c] & ~axis_tready[c]);
      state_d[c] = state_p0[c];
      cnt_d[c]   = cnt_p0[c];
      if (!enable) begin
        state_d[c] = IDLE;
        cnt_d[c]   = '0;
      end else begin
        case (state_p0[c])
          IDLE: begin
            if (stall[c]) begin
              cnt_d[c]   = CNT_W'(1);
              state_d[c] = (STALL_THRESH == 1) ? BLOCKED : COUNT;
            end
          end
          COUNT: begin
            if (stall[c]) begin
              cnt_d[c] = sat_inc(cnt_p0[c]);
              if (cnt_p0[c] == THRESH_M1) state_d[c] = BLOCKED;
            end else begin
              state_d[c] = IDLE;
              cnt_d[c]   = '0;
            end
          end
          BLOCKED: begin
            if (stall[c]) begin
              cnt_d[c] = sat_inc(cnt_p0[c]);
            end else begin
              state_d[c] = IDLE;
              cnt_d[c]   = '0;
            end
          end
          default: begin
            state_d[c] = IDLE;
            cnt_d[c]   = '0;
          end
        endcase
      end
      blk_d[c] = (state_d[c] == BLOCKED);
      entry[c] = blk_d[c] & (state_p0[c] != BLOCKED);
    end
    // Descending scan so the lowest simultaneous entry wins
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (entry[c]) first_sel = IDX_W'(c);
    end
  end

  // Stage p0: channel state, flags and debug capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_p0[c] <= IDLE;
        cnt_p0[c]   <= '0;
      end
      axis_block_sigs <= '0;
      block_any       <= 1'b0;
      first_valid     <= 1'b0;
      first_idx       <= '0;
      block_events    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_p0[c] <= state_d[c];
        cnt_p0[c]   <= cnt_d[c];
      end
      axis_block_sigs <= blk_d;
      block_any       <= |blk_d;
      if (clear) begin
        first_valid  <= 1'b0;
        first_idx    <= '0;
        block_events <= '0;
      end else begin
        block_events <= sat_add_events(block_events, entry);
        if (!first_valid && (|entry)) begin
          first_valid <= 1'b1;
          first_idx   <= first_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_aesl_axis_stall_detector.sv
// Directed bench for aesl_axis_stall_detector: one instance with threshold 8, one with threshold 1.
module tb_aesl_axis_stall_detector;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  tvalid = '0, tready = '0;
  logic [3:0]  sigs;
  logic        any, fv;
  logic [1:0]  fidx;
  logic [15:0] ev;

  logic [3:0]  b_tvalid = '0, b_tready = '0;
  logic [3:0]  b_sigs;
  logic        b_any, b_fv;
  logic [1:0]  b_fidx;
  logic [15:0] b_ev;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  aesl_axis_stall_detector #(
    .NUM_CH(4), .STALL_THRESH(8), .CNT_W(16), .DIR_MASK(4'b0011)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_tvalid(tvalid), .axis_tready(tready),
    .axis_block_sigs(sigs), .block_any(any), .first_valid(fv),
    .first_idx(fidx), .block_events(ev)
  );

  aesl_axis_stall_detector #(
    .NUM_CH(4), .STALL_THRESH(1), .CNT_W(16), .DIR_MASK(4'b0011)
  ) dut_t1 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_tvalid(b_tvalid), .axis_tready(b_tready),
    .axis_block_sigs(b_sigs), .block_any(b_any), .first_valid(b_fv),
    .first_idx(b_fidx), .block_events(b_ev)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    bit hold_ok;

    // Reset state
    tick(3);
    check("rst_sigs", 32'(sigs), 32'h0);
    check("rst_any", 32'(any), 32'h0);
    check("rst_fv", 32'(fv), 32'h0);
    check("rst_ev", 32'(ev), 32'h0);
    reset  = 1'b0;
    enable = 1'b1;
    tick(1);

    // ch0 input port starved for 8 cycles
    tready[0] = 1'b1;
    tick(7);
    check("ch0_pre", 32'(sigs), 32'h0);
    tick(1);
    check("ch0_sigs", 32'(sigs), 32'h1);
    check("ch0_any", 32'(any), 32'h1);
    check("ch0_fv", 32'(fv), 32'h1);
    check("ch0_idx", 32'(fidx), 32'h0);
    check("ch0_ev", 32'(ev), 32'h1);
    tready[0] = 1'b0;
    tick(1);
    check("ch0_drop", 32'(sigs), 32'h0);
    check("ch0_ev_hold", 32'(ev), 32'h1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_fv", 32'(fv), 32'h0);
    check("clr_ev", 32'(ev), 32'h0);

    // ch2 output port: 7 stalls, handshake, 7 stalls
    tvalid[2] = 1'b1;
    tick(7);
    tready[2] = 1'b1;
    tick(1);
    tready[2] = 1'b0;
    tick(7);
    check("ch2_sigs", 32'(sigs), 32'h0);
    check("ch2_ev", 32'(ev), 32'h0);
    tvalid[2] = 1'b0;
    tick(1);

    // ch1 (input) and ch3 (output) stall together
    tready[1] = 1'b1;
    tvalid[3] = 1'b1;
    tick(8);
    check("tie_sigs", 32'(sigs), 32'ha);
    check("tie_idx", 32'(fidx), 32'h1);
    check("tie_ev", 32'(ev), 32'h2);
    check("tie_fv", 32'(fv), 32'h1);

    // Disable for one cycle, then re-enable with stall still present
    enable = 1'b0;
    tick(1);
    check("dis_sigs", 32'(sigs), 32'h0);
    check("dis_any", 32'(any), 32'h0);
    enable = 1'b1;
    tick(7);
    check("reen_pre", 32'(sigs), 32'h0);
    tick(1);
    check("reen_sigs", 32'(sigs), 32'ha);
    check("reen_ev", 32'(ev), 32'h4);
    check("reen_idx", 32'(fidx), 32'h1);

    // Clear coincides with ch0 entering BLOCKED
    tready[0] = 1'b1;
    tick(7);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clrhit_sigs", 32'(sigs), 32'hb);
    check("clrhit_fv", 32'(fv), 32'h0);
    check("clrhit_ev", 32'(ev), 32'h0);
    tick(1);
    check("clrhit_fv2", 32'(fv), 32'h0);

    // ch1 drops then re-blocks: captured as the new first
    tready[1] = 1'b0;
    tick(1);
    check("ch1_drop", 32'(sigs), 32'h9);
    tready[1] = 1'b1;
    tick(8);
    check("ch1_re_sigs", 32'(sigs), 32'hb);
    check("ch1_re_fv", 32'(fv), 32'h1);
    check("ch1_re_idx", 32'(fidx), 32'h1);
    check("ch1_re_ev", 32'(ev), 32'h1);

    // Asynchronous reset mid-cycle
    tvalid[2] = 1'b1;
    tick(3);
    reset = 1'b1;
    #1;
    check("arst_sigs", 32'(sigs), 32'h0);
    check("arst_any", 32'(any), 32'h0);
    check("arst_fv", 32'(fv), 32'h0);
    check("arst_ev", 32'(ev), 32'h0);
    tvalid = '0;
    tready = '0;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("post_rst_sigs", 32'(sigs), 32'h0);

    // Threshold 1: single stall cycle flags next cycle
    b_tready[0] = 1'b1;
    tick(1);
    check("t1_sigs", 32'(b_sigs), 32'h1);
    check("t1_ev", 32'(b_ev), 32'h1);
    b_tready[0] = 1'b0;
    tick(1);
    check("t1_drop", 32'(b_sigs), 32'h0);

    // Long stall past counter range: no wrap, flag held
    b_tvalid[3] = 1'b1;
    hold_ok = 1'b1;
    tick(1);
    for (int i = 0; i < 70000; i++) begin
      if (b_sigs !== 4'h8) hold_ok = 1'b0;
      tick(1);
    end
    check("t1_hold", 32'(hold_ok), 32'h1);
    check("t1_hold_sigs", 32'(b_sigs), 32'h8);
    check("t1_hold_ev", 32'(b_ev), 32'h2);
    b_tvalid[3] = 1'b0;
    tick(1);
    check("t1_hold_drop", 32'(b_sigs), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
